// File: rtl/tinker_mem_pkg.sv
// Shared types for the Tinker memory responder: op encoding, response record, default store size.
package tinker_mem_pkg;

  localparam int TAG_W             = 4;
  localparam int DEFAULT_MEM_BYTES = 524288;

  typedef enum logic [1:0] {
    OP_FETCH32 = 2'b00,
    OP_LOAD64  = 2'b01,
    OP_STORE64 = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

endpackage

// File: rtl/tinker_rsp_fifo.sv
// Response FIFO: registered head, no push-to-pop bypass (a push shows up one cycle later);
// a push is taken when full only if a pop happens in the same cycle.
module tinker_rsp_fifo
  import tinker_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rsp_t push_dat,
  input  logic pop,
  output rsp_t pop_dat,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/tinker_mem_responder.sv
// Byte-store responder: access at the accept edge, tagged in-order response LATENCY cycles later.
// Credit limited to RSP_DEPTH outstanding, so a stalled response channel only ever blocks req_ready.
module tinker_mem_responder
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int MW = $clog2(MEM_BYTES);
  localparam int OW = $clog2(RSP_DEPTH + 1);

  op_e                op;
  logic               accept;
  logic               rsp_hs;
  logic               ready_en;
  logic               err;
  logic [OW-1:0]      outs;
  logic [ADDR_W:0]    last_byte;
  logic [MW-1:0]      idx;
  logic [63:0]        rd_dw;
  rsp_t               acc_rsp;
  rsp_t               head;
  logic               fifo_empty;
  logic               fifo_full;
  logic [7:0]         mem [MEM_BYTES];
  logic [LATENCY-1:0] pipe_vld;
  rsp_t               pipe_dat [LATENCY];

  assign op        = op_e'(req_op);
  assign req_ready = ready_en && (outs < OW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // One extra address bit so an access running off the top of the address space cannot wrap to "in range".
  assign last_byte = {1'b0, req_addr} + ((op == OP_FETCH32) ? (ADDR_W+1)'(3) : (ADDR_W+1)'(7));
  assign err       = (op == OP_RSVD) || (last_byte >= (ADDR_W+1)'(MEM_BYTES));
  assign idx       = req_addr[MW-1:0];

  always_comb begin
    rd_dw = '0;
    for (int i = 0; i < 8; i++) rd_dw[8*i +: 8] = mem[idx + MW'(i)];
  end

  always_comb begin
    acc_rsp.tag  = req_tag;
    acc_rsp.err  = err;
    acc_rsp.data = '0;
    if (!err) begin
      if (op == OP_FETCH32)     acc_rsp.data = {32'b0, rd_dw[31:0]};
      else if (op == OP_LOAD64) acc_rsp.data = rd_dw;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (op == OP_STORE64) && !err) begin
      for (int i = 0; i < 8; i++) mem[idx + MW'(i)] <= req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_dat[0] <= acc_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outs     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case ({accept, rsp_hs})
        2'b10:   outs <= outs + 1'b1;
        2'b01:   outs <= outs - 1'b1;
        default: outs <= outs;
      endcase
    end
  end

  tinker_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_vld[LATENCY-1]),
    .push_dat (pipe_dat[LATENCY-1]),
    .pop      (rsp_ready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head storage is not cleared by reset, so the outputs are forced to zero while nothing is pending.
  assign rsp_data = rsp_valid ? head.data : '0;
  assign rsp_tag  = rsp_valid ? head.tag  : '0;
  assign rsp_err  = rsp_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Bench for tinker_mem_responder: directed scenarios plus random traffic against a byte-array/queue model.
module tb_tinker_mem_responder;
  import tinker_mem_pkg::*;

  localparam int L  = 2;
  localparam int D  = 4;
  localparam int MB = 524288;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  tinker_mem_responder #(.ADDR_W(32), .MEM_BYTES(MB), .LATENCY(L), .RSP_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
    int          avail;
  } exp_t;

  exp_t     expq[$];
  exp_t     seen[$];
  bit [7:0] mm [int];
  int       n_chk = 0;
  int       n_err = 0;
  int       cyc = 0;
  int       outs_m = 0;
  int       last_pop = -1;
  int       acc_cnt = 0;
  bit       rdy_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: little-endian byte store, range check against the store size, store applied at accept.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [63:0] wd, input logic [3:0] tag);
    exp_t   e;
    longint sz;
    sz      = (op == 2'b00) ? 4 : 8;
    e.tag   = tag;
    e.data  = '0;
    e.avail = 0;
    e.err   = (op == 2'b11) || (longint'(addr) + sz > MB);
    if (!e.err) begin
      if (op == 2'b10) begin
        for (int i = 0; i < 8; i++) mm[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++)
          e.data[8*i +: 8] = mm.exists(int'(addr) + i) ? mm[int'(addr) + i] : 8'h00;
      end
    end
    return e;
  endfunction

  // Observed at the falling edge: what happens at the next rising edge is already decided.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_rv;
    if (!reset) begin
      rdy_en   = 1'b0;
      outs_m   = 0;
      last_pop = -1;
      expq.delete();
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_tag", rsp_tag, 0);
      check_eq("rst_rsp_err", rsp_err, 0);
    end else begin
      exp_rv = 1'b0;
      if (expq.size() != 0) exp_rv = (cyc >= expq[0].avail) && (cyc > last_pop);
      check_eq("rsp_valid", rsp_valid, exp_rv);
      check_eq("req_ready", req_ready, rdy_en && (outs_m < D));
      if (rsp_valid && rsp_ready && expq.size() != 0) begin
        e = expq.pop_front();
        check_eq("rsp_data", rsp_data, e.data);
        check_eq("rsp_tag", rsp_tag, e.tag);
        check_eq("rsp_err", rsp_err, e.err);
        e.data = rsp_data; e.tag = rsp_tag; e.err = rsp_err;
        seen.push_back(e);
        last_pop = cyc;
        outs_m--;
      end
      if (req_valid && req_ready) begin
        e       = model(req_op, req_addr, req_wdata, req_tag);
        e.avail = cyc + 1 + L;
        expq.push_back(e);
        outs_m++;
        acc_cnt++;
      end
      rdy_en = 1'b1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [3:0] tag);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_tag = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    check_eq("send_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (expq.size() != 0 && n < 200);
    check_eq("drain", expq.size(), 0);
    #1;
  endtask

  task automatic check_seen(input string name, input int k, input logic [63:0] data,
                            input logic [3:0] tag, input logic err);
    if (k < seen.size()) begin
      check_eq({name, "_data"}, seen[k].data, data);
      check_eq({name, "_tag"}, seen[k].tag, tag);
      check_eq({name, "_err"}, seen[k].err, err);
    end else begin
      check_eq({name, "_count"}, seen.size(), k + 1);
    end
  endtask

  initial begin
    int          t0;
    int          a0;
    int          r;
    logic [31:0] addr;
    logic [63:0] orig;

    // Reset held with a request pending
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    idle(3);
    check_eq("reset_ready", req_ready, 0);
    check_eq("reset_valid", rsp_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_before_first_edge", req_ready, 0);
    @(posedge clk); #1;
    check_eq("ready_after_first_edge", req_ready, 1);
    req_valid = 1'b0;

    for (int a = 'h100; a < 'h200; a += 8) send(2'b10, a, {$urandom, $urandom}, 4'(a >> 3));
    for (int a = 'h7FF00; a < 'h80000; a += 8) send(2'b10, a, {$urandom, $urandom}, 4'(a >> 3));
    drain();

    // Store then load/fetch of the same bytes
    seen.delete();
    send(2'b10, 32'h100, 64'h0123456789ABCDEF, 4'd1);
    send(2'b01, 32'h100, 64'h0, 4'd2);
    send(2'b00, 32'h104, 64'h0, 4'd3);
    drain();
    check_seen("st", 0, 64'h0, 4'd1, 1'b0);
    check_seen("ld", 1, 64'h0123456789ABCDEF, 4'd2, 1'b0);
    check_seen("fetch", 2, 64'h0000000001234567, 4'd3, 1'b0);

    // Backpressure: credits run out at D, one frees the cycle after the first pop
    seen.delete();
    rsp_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) send(2'b01, 32'h108 + 32'(8 * i), 64'h0, 4'(i));
    req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h140; req_tag = 4'd4;
    idle(5);
    check_eq("bp_accepts", acc_cnt - a0, 4);
    check_eq("bp_ready_low", req_ready, 0);
    t0 = cyc;
    rsp_ready = 1'b1;
    send(2'b01, 32'h140, 64'h0, 4'd4);
    check_eq("bp_ready_after_pop", cyc - t0, 2);
    send(2'b01, 32'h148, 64'h0, 4'd5);
    drain();
    for (int i = 0; i < 6; i++) check_eq("bp_order", (i < seen.size()) ? seen[i].tag : 4'hF, 4'(i));

    // Range errors and reserved op; the bad store must not touch memory
    seen.delete();
    orig = '0;
    for (int i = 0; i < 8; i++) orig[8*i +: 8] = mm['h7FFF0 + i];
    send(2'b01, 32'h7FFFC, 64'h0, 4'd6);
    send(2'b11, 32'h0, 64'h0, 4'd7);
    send(2'b10, 32'h7FFF9, 64'hDEADBEEFDEADBEEF, 4'd8);
    send(2'b01, 32'h7FFF0, 64'h0, 4'd9);
    drain();
    check_seen("err_ld", 0, 64'h0, 4'd6, 1'b1);
    check_seen("err_rsvd", 1, 64'h0, 4'd7, 1'b1);
    check_seen("err_st", 2, 64'h0, 4'd8, 1'b1);
    check_seen("err_unchanged", 3, orig, 4'd9, 1'b0);

    // Sustained traffic: one accept per cycle
    t0 = cyc;
    for (int i = 0; i < 12; i++) send(2'b01, 32'h100 + $urandom_range(0, 'hF0), 64'h0, 4'(i));
    check_eq("stream_cycles", cyc - t0, 12);
    drain();

    // Reset with responses in flight; the earlier store survives
    rsp_ready = 1'b0;
    send(2'b10, 32'h180, 64'hCAFEF00D12345678, 4'd10);
    send(2'b01, 32'h100, 64'h0, 4'd11);
    send(2'b00, 32'h104, 64'h0, 4'd12);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(6);
    check_eq("post_rst_valid", rsp_valid, 0);
    check_eq("post_rst_ready", req_ready, 1);
    rsp_ready = 1'b1;
    seen.delete();
    send(2'b01, 32'h180, 64'h0, 4'd13);
    drain();
    check_seen("store_survives", 0, 64'hCAFEF00D12345678, 4'd13, 1'b0);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      rsp_ready = ($urandom_range(0, 9) < 7) || (outs_m >= D);
      if ($urandom_range(0, 3) != 0) begin
        r    = $urandom_range(0, 9);
        addr = ($urandom_range(0, 3) != 0) ? 32'h100 + $urandom_range(0, 'hF0)
                                           : 32'h7FF00 + $urandom_range(0, 'hFF);
        send((r < 3) ? 2'b01 : (r < 6) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11,
             addr, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
